// File: rtl/inst_prefetch_queue_pkg.sv
// Shared widths, state encodings and the queue entry layout for the instruction prefetch queue.
package inst_prefetch_queue_pkg;

   localparam int SYS_ADDR_SPACE = 32;
   localparam int INST_WIDTH     = 32;

   localparam logic [SYS_ADDR_SPACE-1:0] PC_STEP = 32'd4;

   typedef enum logic {
      PQ_RUN   = 1'b0,
      PQ_FLUSH = 1'b1
   } pq_state_t;

   typedef struct packed {
      logic [SYS_ADDR_SPACE-1:0] pc;
      logic [INST_WIDTH-1:0]     inst;
   } pq_entry_t;

endpackage

// File: rtl/inst_prefetch_queue_pq_fifo.sv
// Synchronous FIFO, DEPTH a power of two; registered push, read data combinational from the head.
// Pop on empty is ignored; push on full is accepted only with a same-cycle pop; clear beats push.
module pq_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [CW-1:0]    cnt;
   logic             do_push;
   logic             do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == CW'(DEPTH));
   assign count   = cnt;
   assign rdata   = mem[rd_ptr];
   assign do_pop  = pop && !empty && !clear;
   assign do_push = push && !clear && (!full || do_pop);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage carries no reset: entries are only ever read behind a valid count.
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: redirect-to-valid is 3 cycles with a 1-cycle memory; IF backpressure fills the
// queue and then stalls issue via credits. PREFETCH_ALIGN_CHECK_EN adds the sticky misaligned-redirect anomaly.
module inst_prefetch_queue
   import inst_prefetch_queue_pkg::*;
#(
   parameter int                        DEPTH    = 4,
   parameter logic [SYS_ADDR_SPACE-1:0] RESET_PC = '0
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [SYS_ADDR_SPACE-1:0] pc_i,
   input  logic                      pc_we_i,
   output logic                      imem_req_o,
   output logic [SYS_ADDR_SPACE-1:0] imem_addr_o,
   input  logic                      imem_gnt_i,
   input  logic                      imem_rvalid_i,
   input  logic [INST_WIDTH-1:0]     imem_rdata_i,
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic [INST_WIDTH-1:0]     inst_o,
   output logic [SYS_ADDR_SPACE-1:0] pc_o,
   output logic                      anomaly_o
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   logic [SYS_ADDR_SPACE-1:0] fetch_pc;
   logic [SYS_ADDR_SPACE-1:0] resp_pc;
   logic [SYS_ADDR_SPACE-1:0] redirect_pc;
   logic [CW-1:0]             inflight;
   logic [CW-1:0]             inflight_next;
   logic [CW-1:0]             drop_cnt;
   logic [CW-1:0]             count;
   logic [CW:0]               credit_used;
   pq_state_t                 state;
   logic                      anomaly;
   logic                      fire;
   logic                      push;
   logic                      pop;
   logic                      empty;
   logic                      unused_full;
   pq_entry_t                 wr_entry;
   pq_entry_t                 rd_entry;

`ifdef PREFETCH_ALIGN_CHECK_EN
   assign redirect_pc = pc_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         anomaly <= 1'b0;
      end else if (pc_we_i && (pc_i[1:0] != 2'b00)) begin
         anomaly <= 1'b1;
      end
   end
`else
   logic unused_align;
   assign unused_align = ^pc_i[1:0];
   assign redirect_pc  = {pc_i[SYS_ADDR_SPACE-1:2], 2'b00};
   assign anomaly      = 1'b0;
`endif

   // Buffered words plus outstanding fetches may never exceed DEPTH, so a response always finds room.
   assign credit_used   = {1'b0, count} + {1'b0, inflight};
   assign imem_req_o    = rst_i && !pc_we_i && !anomaly && (credit_used < DEPTH_W);
   assign imem_addr_o   = fetch_pc;
   assign fire          = imem_req_o && imem_gnt_i;
   assign inflight_next = inflight + CW'(fire) - CW'(imem_rvalid_i);

   assign push     = imem_rvalid_i && (state == PQ_RUN) && !pc_we_i;
   assign wr_entry = '{pc: resp_pc, inst: imem_rdata_i};
   assign valid_o  = !empty && !pc_we_i;
   assign pop      = valid_o && ready_i;
   assign inst_o   = empty ? '0 : rd_entry.inst;
   assign pc_o     = empty ? '0 : rd_entry.pc;
   assign anomaly_o = anomaly;

   pq_fifo #(
      .WIDTH ($bits(pq_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (push),
      .pop   (pop),
      .clear (pc_we_i),
      .wdata (wr_entry),
      .rdata (rd_entry),
      .full  (unused_full),
      .empty (empty),
      .count (count)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         inflight <= '0;
         drop_cnt <= '0;
         state    <= PQ_RUN;
      end else begin
         inflight <= inflight_next;
         if (pc_we_i) begin
            // Everything still outstanding after this cycle belongs to the old stream.
            fetch_pc <= redirect_pc;
            resp_pc  <= redirect_pc;
            drop_cnt <= inflight_next;
            state    <= (inflight_next != '0) ? PQ_FLUSH : PQ_RUN;
         end else begin
            if (fire) fetch_pc <= fetch_pc + PC_STEP;
            if (imem_rvalid_i) begin
               if (state == PQ_FLUSH) begin
                  drop_cnt <= drop_cnt - CW'(1);
                  if (drop_cnt == CW'(1)) state <= PQ_RUN;
               end else begin
                  resp_pc <= resp_pc + PC_STEP;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed and randomized bench for inst_prefetch_queue; the reference tracks the expected fetch and IF streams.
module tb_inst_prefetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_i;
   logic        pc_we;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        valid;
   logic        ready;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        anom;

   always #5 clk = ~clk;

   inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk_i         (clk),
      .rst_i         (rst_n),
      .pc_i          (pc_i),
      .pc_we_i       (pc_we),
      .imem_req_o    (req),
      .imem_addr_o   (addr),
      .imem_gnt_i    (gnt),
      .imem_rvalid_i (rvalid),
      .imem_rdata_i  (rdata),
      .valid_o       (valid),
      .ready_i       (ready),
      .inst_o        (inst),
      .pc_o          (pc),
      .anomaly_o     (anom)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int pops   = 0;
   int occ;
   int lat_min = 1;
   int lat_max = 1;
   logic [31:0] mq_addr[$];
   int          mq_due[$];
   logic [31:0] exp_fetch;
   logic [31:0] exp_out;
   logic        m_anom;
   logic        s_req, s_valid, s_anom;
   logic [31:0] s_addr, s_inst, s_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5a5a_0f0f;
   endfunction

   function automatic logic [31:0] tgt_of(input logic [31:0] p);
`ifdef PREFETCH_ALIGN_CHECK_EN
      return p;
`else
      return {p[31:2], 2'b00};
`endif
   endfunction

   function automatic logic resp_due();
      return (mq_due.size() > 0) && (mq_due[0] <= cyc);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq_addr.delete();
      mq_due.delete();
      exp_fetch = RESET_PC;
      exp_out   = RESET_PC;
      occ       = 0;
      m_anom    = 1'b0;
   endtask

   // Reference: requests must walk sequentially from the last redirect, IF must see the same
   // sequence with matching memory words, and live words never exceed DEPTH.
   task automatic model_step();
      chk("anomaly", {31'b0, s_anom}, {31'b0, m_anom});
      if (rvalid) begin
         void'(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end
      if (m_anom) chk("req_blocked", {31'b0, s_req}, 32'd0);
      if (s_req && gnt) begin
         chk("req_addr", s_addr, exp_fetch);
         mq_addr.push_back(s_addr);
         mq_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
         exp_fetch = exp_fetch + 32'd4;
         occ++;
      end
      if (s_valid && ready) begin
         chk("out_pc", s_pc, exp_out);
         chk("out_inst", s_inst, mem_word(exp_out));
         exp_out = exp_out + 32'd4;
         occ--;
         pops++;
      end
      if (pc_we) begin
         chk("redir_req", {31'b0, s_req}, 32'd0);
         chk("redir_valid", {31'b0, s_valid}, 32'd0);
         exp_fetch = tgt_of(pc_i);
         exp_out   = tgt_of(pc_i);
         occ       = 0;
`ifdef PREFETCH_ALIGN_CHECK_EN
         if (pc_i[1:0] != 2'b00) m_anom = 1'b1;
`endif
      end
      chk("occupancy_bound", {31'b0, occ <= DEPTH}, 32'd1);
   endtask

   task automatic tick();
      if (rst_n && resp_due()) begin
         rvalid = 1'b1;
         rdata  = mem_word(mq_addr[0]);
      end else begin
         rvalid = 1'b0;
         rdata  = $urandom;
      end
      @(negedge clk);
      s_req = req; s_addr = addr; s_valid = valid; s_inst = inst; s_pc = pc; s_anom = anom;
      if (rst_n) model_step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req"}, {31'b0, req}, 32'd0);
      chk({tag, "_addr"}, addr, RESET_PC);
      chk({tag, "_valid"}, {31'b0, valid}, 32'd0);
      chk({tag, "_inst"}, inst, 32'd0);
      chk({tag, "_pc"}, pc, 32'd0);
      chk({tag, "_anom"}, {31'b0, anom}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int k;
      logic [31:0] a0;
      rst_n = 1'b0; pc_i = '0; pc_we = 1'b0; gnt = 1'b0; ready = 1'b0;
      rvalid = 1'b0; rdata = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("rst");

      // Sequential fetch from reset with a 1-cycle memory
      gnt = 1'b1; ready = 1'b1; rst_n = 1'b1; cyc = 0;
      tick(); chk("t1_req_c0", {31'b0, s_req}, 32'd1); chk("t1_addr_c0", s_addr, 32'h0);
              chk("t1_valid_c0", {31'b0, s_valid}, 32'd0);
      tick(); chk("t1_addr_c1", s_addr, 32'h4); chk("t1_valid_c1", {31'b0, s_valid}, 32'd0);
      tick(); chk("t1_valid_c2", {31'b0, s_valid}, 32'd1); chk("t1_pc_c2", s_pc, 32'h0);
      tick(); chk("t1_pc_c3", s_pc, 32'h4);
      repeat (6) tick();

      // IF stall: queue fills to DEPTH, issue stops, then drains in order
      ready = 1'b0;
      repeat (10) tick();
      chk("t2_req_stalled", {31'b0, s_req}, 32'd0);
      chk("t2_head_valid", {31'b0, s_valid}, 32'd1);
      chk("t2_live_words", occ, DEPTH);
      chk("t2_none_inflight", mq_addr.size(), 32'd0);
      ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t2_drain_valid", {31'b0, s_valid}, 32'd1);
      end

      // Redirect with three responses outstanding
      lat_min = 4; lat_max = 4;
      k = 0;
      while (mq_addr.size() != 3 && k < 30) begin tick(); k++; end
      chk("t3_setup", {31'b0, k < 30}, 32'd1);
      pc_i = 32'h100; pc_we = 1'b1;
      tick();
      pc_we = 1'b0;
      k = 0;
      while (!s_valid && k < 30) begin tick(); k++; end
      chk("t3_valid_seen", {31'b0, s_valid}, 32'd1);
      chk("t3_first_pc", s_pc, 32'h100);

      // Redirect-to-valid latency from an idle queue
      lat_min = 1; lat_max = 1; gnt = 1'b0;
      repeat (8) tick();
      chk("t3b_idle", mq_addr.size(), 32'd0);
      chk("t3b_empty", {31'b0, s_valid}, 32'd0);
      pc_i = 32'h200; pc_we = 1'b1; gnt = 1'b1;
      tick(); chk("t3b_req_T", {31'b0, s_req}, 32'd0);
      pc_we = 1'b0;
      tick(); chk("t3b_req_T1", {31'b0, s_req}, 32'd1); chk("t3b_addr_T1", s_addr, 32'h200);
      tick(); chk("t3b_valid_T2", {31'b0, s_valid}, 32'd0);
      tick(); chk("t3b_valid_T3", {31'b0, s_valid}, 32'd1); chk("t3b_pc_T3", s_pc, 32'h200);

      // Redirect coincident with a response while credits are exhausted
      ready = 1'b0; lat_min = 2; lat_max = 2;
      k = 0;
      while (!(resp_due() && mq_addr.size() >= 2) && k < 40) begin tick(); k++; end
      chk("t4_setup", {31'b0, k < 40}, 32'd1);
      pc_i = 32'h300; pc_we = 1'b1;
      tick();
      pc_we = 1'b0;
      tick(); chk("t4_empty_next", {31'b0, s_valid}, 32'd0);
      ready = 1'b1;
      k = 0;
      while (!s_valid && k < 30) begin tick(); k++; end
      chk("t4_first_pc", s_pc, 32'h300);

      // Grant withheld: request and address hold
      lat_min = 1; lat_max = 1; gnt = 1'b0;
      tick();
      a0 = s_addr;
      chk("t5_addr_model", a0, exp_fetch);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t5_addr_stable", s_addr, a0);
         chk("t5_req_held", {31'b0, s_req}, 32'd1);
      end
      gnt = 1'b1;
      repeat (3) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("t5_arst");
      model_reset();
      repeat (2) tick();
      rst_n = 1'b1;
      tick(); chk("t5_restart_req", {31'b0, s_req}, 32'd1); chk("t5_restart_addr", s_addr, RESET_PC);

      // Address wrap, then randomized traffic
      pc_i = 32'hFFFF_FFF8; pc_we = 1'b1;
      tick();
      pc_we = 1'b0;
      repeat (10) tick();
      lat_min = 1; lat_max = 3;
      for (int i = 0; i < 2500; i++) begin
         gnt   = ($urandom_range(0, 3) != 0);
         ready = ((i % 300) >= 20) && ($urandom_range(0, 3) != 0);
         pc_we = ($urandom_range(0, 31) == 0);
`ifdef PREFETCH_ALIGN_CHECK_EN
         pc_i  = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
`else
         pc_i  = $urandom;
`endif
         tick();
      end
      pc_we = 1'b0; gnt = 1'b1; ready = 1'b1; lat_min = 1; lat_max = 1;
      k = 0;
      while (!s_valid && k < 20) begin tick(); k++; end
      chk("live_valid", {31'b0, s_valid}, 32'd1);
      chk("live_pops", {31'b0, pops > 200}, 32'd1);

      // Misaligned redirect
      pc_i = 32'h102; pc_we = 1'b1;
      tick();
      pc_we = 1'b0;
      tick();
`ifdef PREFETCH_ALIGN_CHECK_EN
      chk("t6_anomaly", {31'b0, s_anom}, 32'd1);
      chk("t6_no_req", {31'b0, s_req}, 32'd0);
      repeat (6) tick();
      chk("t6_still_no_req", {31'b0, s_req}, 32'd0);
      chk("t6_drained", {31'b0, s_valid}, 32'd0);
`else
      chk("t6_anomaly", {31'b0, s_anom}, 32'd0);
      chk("t6_req", {31'b0, s_req}, 32'd1);
      chk("t6_addr", s_addr, 32'h100);
      repeat (4) tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
